// File: rtl/dram_req_arbiter.sv
// Two-master arbiter for the DRAM wrapper slave port: one-cycle select pulse,
// command held through wait states, per-transfer timeout and busy-cycle counter.
module dram_req_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prio_fixed,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [1:0]        m_done,
  output logic              m_err,
  output logic [DATA_W-1:0] m_rdata,
  output logic              d_sel,
  output logic [ADDR_W-1:0] d_addr,
  output logic              d_write,
  output logic [DATA_W-1:0] d_wdata,
  input  logic              d_ready,
  input  logic [DATA_W-1:0] d_rdata,
  output logic [CNT_W-1:0]  busy_cnt
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic                cmd_write_q, cmd_write_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;
  logic                grant;

  // Winner among current requesters; only consumed while IDLE with a request.
  always_comb begin
    grant = 1'b0;
    if (prio_fixed) begin
      grant = ~m_req[0];
    end else if (&m_req) begin
      grant = ~last_grant_q;
    end else begin
      grant = m_req[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_write_d  = cmd_write_q;
    cmd_wdata_d  = cmd_wdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    err_d        = err_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (|m_req) begin
          owner_d     = grant;
          cmd_addr_d  = grant ? m1_addr  : m0_addr;
          cmd_write_d = grant ? m_write[1] : m_write[0];
          cmd_wdata_d = grant ? m1_wdata : m0_wdata;
          err_d       = 1'b0;
          rdata_d     = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // A ready on the final allowed cycle still completes normally.
        if (d_ready) begin
          rdata_d = d_rdata;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (timer_q == TMR_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        timer_d      = '0;
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (state_q != S_IDLE && busy_cnt_q != '1) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_addr_q   <= '0;
      cmd_write_q  <= 1'b0;
      cmd_wdata_q  <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      busy_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_write_q  <= cmd_write_d;
      cmd_wdata_q  <= cmd_wdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      busy_cnt_q   <= busy_cnt_d;
    end
  end

  always_comb begin
    d_sel    = (state_q == S_ISSUE);
    d_addr   = cmd_addr_q;
    d_write  = cmd_write_q;
    d_wdata  = cmd_wdata_q;
    m_done   = 2'b00;
    m_err    = 1'b0;
    m_rdata  = '0;
    busy_cnt = busy_cnt_q;
    if (state_q == S_DONE) begin
      m_done  = owner_q ? 2'b10 : 2'b01;
      m_err   = err_q;
      m_rdata = (cmd_write_q || err_q) ? '0 : rdata_q;
    end
  end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Bench for dram_req_arbiter: directed vector table, hand sequences for reset
// and idle-ready corners, then random traffic against a transaction-level model.
module tb_dram_req_arbiter;

  localparam int T    = 8;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk, rst, prio_fixed, d_sel, d_write, d_ready, m_err;
  logic [1:0]  m_req, m_write, m_done;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m_rdata, d_addr, d_wdata, d_rdata;
  logic [CW-1:0] busy_cnt;

  int checks = 0;
  int failures = 0;

  dram_req_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .prio_fixed(prio_fixed), .m_req(m_req), .m_write(m_write),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m_done(m_done), .m_err(m_err), .m_rdata(m_rdata), .d_sel(d_sel), .d_addr(d_addr),
    .d_write(d_write), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          prio;
    bit [1:0]    req;
    bit [1:0]    wr;
    logic [31:0] a0, a1, w0, w1;
    int          dly;      // ready this many cycles after d_sel; 0 = never
    logic [31:0] rd;
    int          own;
    bit          err;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(bit prio, bit [1:0] req, bit [1:0] wr, logic [31:0] a0,
                              logic [31:0] a1, logic [31:0] w0, logic [31:0] w1, int dly,
                              logic [31:0] rd, int own, bit err, logic [31:0] exp_rdata);
    vec_t v;
    v.prio = prio; v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.dly = dly; v.rd = rd; v.own = own; v.err = err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    bit found;
    int done_k, exp_k;
    logic [31:0] ea, ew;
    bit ewr;
    string tag;
    tag = $sformatf("v%0d", idx);
    ea  = (v.own == 1) ? v.a1 : v.a0;
    ew  = (v.own == 1) ? v.w1 : v.w0;
    ewr = v.wr[v.own];
    prio_fixed = v.prio; m_req = v.req; m_write = v.wr;
    m0_addr = v.a0; m1_addr = v.a1; m0_wdata = v.w0; m1_wdata = v.w1;
    d_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (d_sel) begin found = 1; break; end
    end
    chk({tag, "_sel_seen"}, 64'(found), 64'd1);
    chk({tag, "_addr"}, 64'(d_addr), 64'(ea));
    chk({tag, "_write"}, 64'(d_write), 64'(ewr));
    if (ewr) chk({tag, "_wdata"}, 64'(d_wdata), 64'(ew));
    done_k = -1;
    for (int i = 1; i <= T + 4; i++) begin
      @(negedge clk);
      d_ready = (i == v.dly);
      d_rdata = (i == v.dly) ? v.rd : $urandom;
      if (m_done != 2'b00) begin done_k = i; break; end
      chk({tag, "_sel_low"}, 64'(d_sel), 64'd0);
      chk({tag, "_hold_write"}, 64'(d_write), 64'(ewr));
      if (ewr) chk({tag, "_hold_wdata"}, 64'(d_wdata), 64'(ew));
    end
    exp_k = (v.dly >= 1 && v.dly <= T) ? v.dly + 1 : T + 1;
    chk({tag, "_done_cycle"}, 64'(done_k), 64'(exp_k));
    chk({tag, "_done_owner"}, 64'(m_done), (v.own == 1) ? 64'd2 : 64'd1);
    chk({tag, "_err"}, 64'(m_err), 64'(v.err));
    chk({tag, "_rdata"}, 64'(m_rdata), 64'(v.exp_rdata));
    d_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_single"}, 64'(m_done), 64'd0);
  endtask

  vec_t vecs[$];
  vec_t vr;
  bit   found6;

  // random-phase model state
  int          act, idle_prev, own_m, last_m, sel_c, done_c, dly_m, busy_m;
  bit          err_m, wr_m, prev_prio;
  logic [31:0] addr_m, wdata_m, rdexp_m, rd_m;
  logic [1:0]  prev_req, exp_done;
  logic [31:0] pa0, pa1, pw0, pw1;
  logic [1:0]  pwr;
  int          gap[2];
  bit          in_wait;

  initial begin
    rst = 1'b1; prio_fixed = 1'b0; m_req = 2'b00; m_write = 2'b00;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    d_ready = 1'b0; d_rdata = '0;

    vecs.push_back(mk(0, 2'b01, 2'b00, 32'h104,  32'h300,  32'h0, 32'h0,        6, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 2'b10, 2'b10, 32'h104,  32'h200,  32'h0, 32'hA5A55A5A, 5, 32'h12345678, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        2, 32'h11111111, 0, 0, 32'h11111111));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        2, 32'h22222222, 1, 0, 32'h22222222));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        3, 32'h33333333, 0, 0, 32'h33333333));
    vecs.push_back(mk(0, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        3, 32'h44444444, 1, 0, 32'h44444444));
    vecs.push_back(mk(1, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        2, 32'h55555555, 0, 0, 32'h55555555));
    vecs.push_back(mk(1, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        2, 32'h66666666, 0, 0, 32'h66666666));
    vecs.push_back(mk(1, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        2, 32'h77777777, 0, 0, 32'h77777777));
    vecs.push_back(mk(1, 2'b11, 2'b00, 32'h1000, 32'h2000, 32'h0, 32'h0,        2, 32'h88888888, 0, 0, 32'h88888888));
    vecs.push_back(mk(1, 2'b10, 2'b10, 32'h1000, 32'h2000, 32'h0, 32'hCAFEF00D, 1, 32'hFFFF0000, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b01, 32'h1000, 32'h2000, 32'h0BADC0DE, 32'h0, 8, 32'hABABABAB, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 32'h40,   32'h2000, 32'h0, 32'h0,        0, 32'h0,        0, 1, 32'h0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 32'h40,   32'h44,   32'h0, 32'h0,        8, 32'h99999999, 1, 0, 32'h99999999));
    vecs.push_back(mk(0, 2'b01, 2'b00, 32'h48,   32'h44,   32'h0, 32'h0,        9, 32'h5A5A5A5A, 0, 1, 32'h0));

    // reset state
    #7;
    chk("rst_d_sel", 64'(d_sel), 64'd0);
    chk("rst_m_done", 64'(m_done), 64'd0);
    chk("rst_busy", 64'(busy_cnt), 64'd0);
    chk("rst_d_addr", 64'(d_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // idle-ready immunity
    d_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_ready_done", 64'(m_done), 64'd0);
      chk("idle_ready_busy", 64'(busy_cnt), 64'd0);
    end
    d_ready = 1'b0;

    foreach (vecs[i]) begin
      run_vec(vecs[i], i);
      if (i == 12) begin
        m_req = 2'b00;
        d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("late_ready_done", 64'(m_done), 64'd0);
          chk("late_ready_sel", 64'(d_sel), 64'd0);
        end
        d_ready = 1'b0;
      end
    end

    // reset three cycles into WAIT; last grant was master 0 so a tie would go to master 1
    prio_fixed = 1'b0; m_req = 2'b10; m_write = 2'b00; m1_addr = 32'h500;
    found6 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (d_sel) begin found6 = 1; break; end
    end
    chk("rstw_sel_seen", 64'(found6), 64'd1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstw_d_sel", 64'(d_sel), 64'd0);
    chk("rstw_d_addr", 64'(d_addr), 64'd0);
    chk("rstw_d_write", 64'(d_write), 64'd0);
    chk("rstw_d_wdata", 64'(d_wdata), 64'd0);
    chk("rstw_m_done", 64'(m_done), 64'd0);
    chk("rstw_m_err", 64'(m_err), 64'd0);
    chk("rstw_m_rdata", 64'(m_rdata), 64'd0);
    chk("rstw_busy", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0; m_req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw_no_done", 64'(m_done), 64'd0);
    end
    vr = mk(0, 2'b11, 2'b00, 32'h600, 32'h700, 32'h0, 32'h0, 2, 32'h13572468, 0, 0, 32'h13572468);
    run_vec(vr, 99);

    // random traffic against a transaction-level model
    m_req = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    act = 0; idle_prev = 1; last_m = 1; busy_m = 0;
    sel_c = 0; done_c = 0; dly_m = 0; own_m = 0; err_m = 0; wr_m = 0;
    addr_m = '0; wdata_m = '0; rdexp_m = '0; rd_m = '0;
    prev_req = 2'b00; prev_prio = prio_fixed;
    pa0 = m0_addr; pa1 = m1_addr; pw0 = m0_wdata; pw1 = m1_wdata; pwr = m_write;
    gap[0] = 0; gap[1] = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (act == 0 && idle_prev == 1 && prev_req != 2'b00) begin
        if (prev_prio) own_m = prev_req[0] ? 0 : 1;
        else if (prev_req == 2'b11) own_m = 1 - last_m;
        else own_m = prev_req[1] ? 1 : 0;
        act = 1; sel_c = c;
        addr_m  = (own_m == 1) ? pa1 : pa0;
        wdata_m = (own_m == 1) ? pw1 : pw0;
        wr_m    = pwr[own_m];
        dly_m   = $urandom_range(1, T + 3);
        rd_m    = $urandom;
        err_m   = (dly_m > T);
        done_c  = c + 1 + (err_m ? T : dly_m);
        rdexp_m = (err_m || wr_m) ? 32'h0 : rd_m;
      end
      in_wait  = (act == 1) && c > sel_c && c < done_c;
      exp_done = (act == 1 && c == done_c) ? ((own_m == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_sel", 64'(d_sel), 64'(act == 1 && c == sel_c));
      chk("rnd_done", 64'(m_done), 64'(exp_done));
      chk("rnd_err", 64'(m_err), 64'(act == 1 && c == done_c && err_m));
      if (exp_done != 2'b00) chk("rnd_rdata", 64'(m_rdata), 64'(rdexp_m));
      if (act == 1 && c < done_c) begin
        chk("rnd_addr", 64'(d_addr), 64'(addr_m));
        chk("rnd_write", 64'(d_write), 64'(wr_m));
        if (wr_m) chk("rnd_wdata", 64'(d_wdata), 64'(wdata_m));
      end
      chk("rnd_busy", 64'(busy_cnt), 64'(busy_m));

      if (in_wait && !err_m && c == sel_c + dly_m) begin
        d_ready = 1'b1; d_rdata = rd_m;
      end else if (in_wait) begin
        d_ready = 1'b0; d_rdata = $urandom;
      end else begin
        d_ready = 1'($urandom_range(0, 1)); d_rdata = $urandom;
      end

      if (act == 1) busy_m = (busy_m == CMAX) ? CMAX : busy_m + 1;
      if (act == 1 && c == done_c) begin
        act = 0; last_m = own_m; idle_prev = 0;
      end else begin
        idle_prev = (act == 0) ? 1 : 0;
      end

      for (int i = 0; i < 2; i++) begin
        if (m_req[i] && exp_done[i]) begin
          m_req[i] = 1'b0; gap[i] = $urandom_range(0, 3);
        end else if (!m_req[i]) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            m_req[i] = 1'b1;
            m_write[i] = 1'($urandom_range(0, 1));
            if (i == 0) begin m0_addr = $urandom; m0_wdata = $urandom; end
            else begin m1_addr = $urandom; m1_wdata = $urandom; end
          end
        end
      end
      if ($urandom_range(0, 99) < 4) prio_fixed = ~prio_fixed;
      prev_req = m_req; prev_prio = prio_fixed; pwr = m_write;
      pa0 = m0_addr; pa1 = m1_addr; pw0 = m0_wdata; pw1 = m1_wdata;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
